// File: rtl/carfield_addr_rule_decoder.sv
// Programmable address-rule decoder: priority rule match, 2/4-way port interleave, lockable map, miss counter.
// Optional build macro CARFIELD_ADDR_RULE_OVERLAP_CHECK_EN rejects enabled rule writes that intersect another enabled rule.
`timescale 1ns/1ps
module carfield_addr_rule_decoder #(
  parameter int NumRules    = 8,
  parameter int NumPorts    = 8,
  parameter int AddrWidth   = 48,
  parameter int IntlvLsb    = 3,
  parameter int MissCntW    = 16,
  parameter int DefaultPort = 0,
  localparam int IdxW  = $clog2(NumRules),
  localparam int PortW = $clog2(NumPorts)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_size_i,
  input  logic [PortW-1:0]     cfg_port_i,
  input  logic [1:0]           cfg_intlv_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  output logic                 locked_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 dec_valid_o,
  input  logic                 dec_ready_i,
  output logic [PortW-1:0]     dec_port_o,
  output logic [IdxW-1:0]      dec_rule_o,
  output logic                 dec_err_o,
  output logic [MissCntW-1:0]  miss_cnt_o
);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e state_q, state_d;
  logic   run_q;

  logic [AddrWidth-1:0] base_q  [NumRules];
  logic [AddrWidth-1:0] size_q  [NumRules];
  logic [PortW-1:0]     port_q  [NumRules];
  logic [1:0]           intlv_q [NumRules];
  logic                 en_q    [NumRules];
  logic [AddrWidth:0]   end_q   [NumRules];

  logic cfg_fire, cfg_write, cfg_drop, overlap;
  logic accept;

  // Range ends carry one extra bit so a rule touching the top of the space never wraps.
  always_comb begin
    for (int i = 0; i < NumRules; i++) begin
      end_q[i] = {1'b0, base_q[i]} + {1'b0, size_q[i]};
    end
  end

  assign cfg_fire = cfg_valid_i && cfg_ready_o;

`ifdef CARFIELD_ADDR_RULE_OVERLAP_CHECK_EN
  logic [AddrWidth:0] cfg_end;
  assign cfg_end = {1'b0, cfg_base_i} + {1'b0, cfg_size_i};

  always_comb begin
    overlap = 1'b0;
    if (cfg_en_i && (cfg_size_i != '0)) begin
      for (int i = 0; i < NumRules; i++) begin
        if ((IdxW'(i) != cfg_idx_i) && en_q[i] && (size_q[i] != '0) &&
            ({1'b0, cfg_base_i} < end_q[i]) && ({1'b0, base_q[i]} < cfg_end)) begin
          overlap = 1'b1;
        end
      end
    end
  end
`else
  assign overlap = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UNLOCKED;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // A write presented together with the lock pulse still lands before the map closes.
  always_comb begin
    state_d   = state_q;
    cfg_write = 1'b0;
    cfg_drop  = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (cfg_fire) begin
          cfg_write = !overlap;
          cfg_drop  = overlap;
        end
        if (cfg_lock_i) state_d = LOCKED;
      end
      LOCKED: begin
        cfg_drop = cfg_fire;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  assign locked_o    = (state_q == LOCKED);
  assign cfg_ready_o = run_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_err_o <= 1'b0;
      for (int i = 0; i < NumRules; i++) begin
        base_q[i]  <= '0;
        size_q[i]  <= '0;
        port_q[i]  <= '0;
        intlv_q[i] <= '0;
        en_q[i]    <= 1'b0;
      end
    end else begin
      cfg_err_o <= cfg_drop;
      if (cfg_write) begin
        base_q[cfg_idx_i]  <= cfg_base_i;
        size_q[cfg_idx_i]  <= cfg_size_i;
        port_q[cfg_idx_i]  <= cfg_port_i;
        intlv_q[cfg_idx_i] <= cfg_intlv_i;
        en_q[cfg_idx_i]    <= cfg_en_i;
      end
    end
  end

  logic             hit;
  logic [IdxW-1:0]  hit_idx;
  logic [PortW-1:0] sel_port;
  logic [1:0]       sel_intlv;
  logic [1:0]       offset;
  logic [PortW:0]   port_sum;
  logic [PortW-1:0] hit_port;

  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    sel_port  = '0;
    sel_intlv = '0;
    for (int i = 0; i < NumRules; i++) begin
      if (!hit && en_q[i] && (size_q[i] != '0) &&
          ({1'b0, req_addr_i} >= {1'b0, base_q[i]}) && ({1'b0, req_addr_i} < end_q[i])) begin
        hit       = 1'b1;
        hit_idx   = IdxW'(i);
        sel_port  = port_q[i];
        sel_intlv = intlv_q[i];
      end
    end
    case (sel_intlv)
      2'd1:    offset = {1'b0, req_addr_i[IntlvLsb]};
      2'd2:    offset = req_addr_i[IntlvLsb+1:IntlvLsb];
      default: offset = 2'd0;
    endcase
    port_sum = {1'b0, sel_port} + (PortW+1)'(offset);
    hit_port = PortW'(port_sum % (PortW+1)'(NumPorts));
  end

  assign req_ready_o = run_q && (!dec_valid_o || dec_ready_i);
  assign accept      = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_valid_o <= 1'b0;
      dec_port_o  <= '0;
      dec_rule_o  <= '0;
      dec_err_o   <= 1'b0;
      miss_cnt_o  <= '0;
    end else begin
      if (accept) begin
        dec_valid_o <= 1'b1;
        dec_port_o  <= hit ? hit_port : PortW'(DefaultPort);
        dec_rule_o  <= hit ? hit_idx : '0;
        dec_err_o   <= !hit;
        if (!hit && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 1'b1;
      end else if (dec_ready_i) begin
        dec_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_carfield_addr_rule_decoder.sv
// Scoreboard bench for carfield_addr_rule_decoder: directed scenarios plus randomized traffic against a rule-list model.
`timescale 1ns/1ps
module tb_carfield_addr_rule_decoder;
  localparam int NR = 8;
  localparam int NP = 8;
  localparam int AW = 48;
  localparam int MISS_MAX = 65535;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_ni;
  logic          cfg_valid_i, cfg_ready_o, cfg_en_i, cfg_lock_i, cfg_err_o, locked_o;
  logic [2:0]    cfg_idx_i, cfg_port_i, dec_port_o, dec_rule_o;
  logic [AW-1:0] cfg_base_i, cfg_size_i, req_addr_i;
  logic [1:0]    cfg_intlv_i;
  logic          req_valid_i, req_ready_o, dec_valid_o, dec_ready_i, dec_err_o;
  logic [15:0]   miss_cnt_o;

  carfield_addr_rule_decoder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_idx_i(cfg_idx_i),
    .cfg_base_i(cfg_base_i), .cfg_size_i(cfg_size_i), .cfg_port_i(cfg_port_i),
    .cfg_intlv_i(cfg_intlv_i), .cfg_en_i(cfg_en_i), .cfg_lock_i(cfg_lock_i),
    .cfg_err_o(cfg_err_o), .locked_o(locked_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i), .dec_port_o(dec_port_o),
    .dec_rule_o(dec_rule_o), .dec_err_o(dec_err_o), .miss_cnt_o(miss_cnt_o)
  );

  // Reference rule table
  longint unsigned m_base [NR];
  longint unsigned m_size [NR];
  int              m_port [NR];
  int              m_intlv[NR];
  bit              m_en   [NR];
  bit              m_locked;
  int              m_miss;
  bit              exp_cfg_err;

  typedef struct { int port; int rule; bit err; int miss; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit last_acc;
  int rdy_mode = 0;  // 0: always ready, 1: never ready, 2: random

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = 0; m_size[i] = 0; m_port[i] = 0; m_intlv[i] = 0; m_en[i] = 1'b0;
    end
    m_locked = 1'b0;
    m_miss = 0;
    exp_cfg_err = 1'b0;
  endtask

  function automatic exp_t ref_decode(input longint unsigned a);
    exp_t r;
    int off;
    r.port = 0; r.rule = 0; r.err = 1'b1; r.miss = 0;
    for (int i = 0; i < NR; i++) begin
      if (m_en[i] && m_size[i] != 0 && a >= m_base[i] && a < m_base[i] + m_size[i]) begin
        off = (m_intlv[i] == 1) ? int'((a >> 3) % 2) : (m_intlv[i] == 2) ? int'((a >> 3) % 4) : 0;
        r.port = (m_port[i] + off) % NP;
        r.rule = i;
        r.err = 1'b0;
        return r;
      end
    end
    return r;
  endfunction

  function automatic bit ref_overlap(input int idx, input longint unsigned b, input longint unsigned s, input bit en);
`ifdef CARFIELD_ADDR_RULE_OVERLAP_CHECK_EN
    if (!en || s == 0) return 1'b0;
    for (int j = 0; j < NR; j++) begin
      if (j != idx && m_en[j] && m_size[j] != 0 && b < m_base[j] + m_size[j] && m_base[j] < b + s)
        return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  // One clock: checks, handshake bookkeeping at the negedge, then the edge.
  task automatic step();
    exp_t e;
    @(negedge clk_i);
    check("cfg_err", cfg_err_o, exp_cfg_err);
    check("locked", locked_o, m_locked);
    check("cfg_ready", cfg_ready_o, 1);
    last_acc = req_valid_i && req_ready_o;
    if (last_acc) begin
      e = ref_decode(req_addr_i);
      if (e.err && m_miss < MISS_MAX) m_miss++;
      e.miss = m_miss;
      exp_q.push_back(e);
    end
    exp_cfg_err = 1'b0;
    if (cfg_valid_i && cfg_ready_o) begin
      if (m_locked || ref_overlap(int'(cfg_idx_i), cfg_base_i, cfg_size_i, cfg_en_i)) begin
        exp_cfg_err = 1'b1;
      end else begin
        m_base[cfg_idx_i]  = cfg_base_i;
        m_size[cfg_idx_i]  = cfg_size_i;
        m_port[cfg_idx_i]  = int'(cfg_port_i);
        m_intlv[cfg_idx_i] = int'(cfg_intlv_i);
        m_en[cfg_idx_i]    = cfg_en_i;
      end
    end
    if (cfg_lock_i) m_locked = 1'b1;
    @(posedge clk_i);
    #1;
    dec_ready_i = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
  endtask

  // Scoreboard monitor: every valid cycle must show the head entry; pop on transfer.
  always @(negedge clk_i) begin
    if (mon_en) begin
      check("req_ready", req_ready_o, !dec_valid_o || dec_ready_i);
      if (dec_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("dec_port", dec_port_o, exp_q[0].port);
          check("dec_rule", dec_rule_o, exp_q[0].rule);
          check("dec_err", dec_err_o, exp_q[0].err);
          check("miss_cnt", miss_cnt_o, exp_q[0].miss);
          if (dec_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_cfg(input int idx, input longint unsigned b, input longint unsigned s,
                        input int p, input int il, input bit en);
    cfg_valid_i = 1'b1;
    cfg_idx_i = 3'(idx); cfg_base_i = AW'(b); cfg_size_i = AW'(s);
    cfg_port_i = 3'(p); cfg_intlv_i = 2'(il); cfg_en_i = en;
    step();
    cfg_valid_i = 1'b0;
  endtask

  task automatic do_req(input longint unsigned a);
    int n = 0;
    req_valid_i = 1'b1;
    req_addr_i = AW'(a);
    step();
    while (!last_acc && n < 200) begin
      step();
      n++;
    end
    if (!last_acc) check("req_timeout", 0, 1);
    req_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc;
    rst_ni = 1'b0;
    cfg_valid_i = 0; cfg_idx_i = 0; cfg_base_i = 0; cfg_size_i = 0; cfg_port_i = 0;
    cfg_intlv_i = 0; cfg_en_i = 0; cfg_lock_i = 0;
    req_valid_i = 0; req_addr_i = 0; dec_ready_i = 1'b1;
    model_reset();
    #1;
    check("rst_dec_valid", dec_valid_o, 0);
    check("rst_cfg_ready", cfg_ready_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    @(posedge clk_i);
    #1 mon_en = 1'b1;
    check("post_rst_miss_cnt", miss_cnt_o, 0);
    check("post_rst_locked", locked_o, 0);

    // Two adjacent windows, last-word / first-word / miss / below-base boundaries
    do_cfg(0, 'h7800_0000, 'h20_0000, 0, 0, 1);
    do_cfg(1, 'h7820_0000, 'h20_0000, 1, 0, 1);
    do_req('h781F_FFF8);
    do_req('h7820_0000);
    do_req('h7840_0000);
    do_req('h77FF_FFF8);
    // Rule reaching past the top of the address space must not wrap to zero
    do_cfg(4, 'hFFFF_FFFF_F000, 'h2000, 5, 0, 1);
    do_req('hFFFF_FFFF_FFF8);
    do_req('h0);

    // Interleaving
    do_cfg(0, 0, 0, 0, 0, 0);
    do_cfg(1, 0, 0, 0, 0, 0);
    do_cfg(2, 'h7800_0000, 'h40_0000, 2, 1, 1);
    do_req('h7800_0000);
    do_req('h7800_0008);
    do_cfg(3, 'h0, 'h100, 7, 2, 1);
    do_req('h10);
    do_req('h18);
    do_req('h08);

    // Overlapping windows
    do_cfg(0, 'h6000_0000, 'h80_0000, 0, 0, 1);
    do_cfg(1, 'h607F_F000, 'h1000, 1, 0, 1);
    do_req('h607F_F000);
    do_cfg(0, 'h6000_0000, 'h80_0000, 0, 0, 0);
    do_req('h607F_F000);
    // Write and accept in the same cycle: the decode sees the old table
    req_valid_i = 1'b1; req_addr_i = AW'('h6000_0010);
    do_cfg(0, 'h6000_0000, 'h80_0000, 6, 0, 1);
    req_valid_i = 1'b0;
    do_req('h6000_0010);

    // Randomized traffic and rule writes with random backpressure
    rdy_mode = 2;
    for (int k = 0; k < 1500; k++) begin
      cfg_valid_i = ($urandom_range(0, 7) == 0);
      cfg_idx_i = 3'($urandom_range(0, 7));
      cfg_base_i = AW'($urandom_range(0, 'h1F) * 'h100);
      cfg_size_i = AW'($urandom_range(0, 'h800));
      cfg_port_i = 3'($urandom_range(0, 7));
      cfg_intlv_i = 2'($urandom_range(0, 3));
      cfg_en_i = ($urandom_range(0, 3) != 0);
      req_valid_i = $urandom_range(0, 1);
      req_addr_i = AW'($urandom_range(0, 'h23FF));
      step();
    end
    cfg_valid_i = 1'b0; req_valid_i = 1'b0;
    rdy_mode = 0; dec_ready_i = 1'b1;
    idle(4);

    // Stall for five cycles, then back-to-back throughput
    rdy_mode = 1; dec_ready_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = AW'('h7800_0008);
    step();
    check("stall_first_acc", last_acc, 1);
    req_addr_i = AW'('h7800_0010);
    repeat (5) begin
      step();
      check("stall_no_acc", last_acc, 0);
    end
    rdy_mode = 0; dec_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("b2b_acc", last_acc, 1);
      req_addr_i = AW'('h7800_0000 + k * 8);
    end
    req_valid_i = 1'b0;
    idle(3);

    // Lock, then a dropped write
    cfg_lock_i = 1'b1;
    step();
    cfg_lock_i = 1'b0;
    do_cfg(3, 'h5000, 'h100, 4, 0, 1);
    idle(1);
    do_req('h10);
    do_req('h5000);

    // Miss counter saturation
    req_valid_i = 1'b1; req_addr_i = AW'('hF000_0000_0000);
    cnt = 0; cyc = 0;
    while (cnt < 65540 && cyc < 70000) begin
      step();
      if (last_acc) cnt++;
      cyc++;
    end
    check("miss_burst_done", cnt, 65540);
    req_valid_i = 1'b0;
    step();
    check("miss_saturated", miss_cnt_o, 'hFFFF);

    // Asynchronous reset during a stall
    rdy_mode = 1; dec_ready_i = 1'b0;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    step();
    #3;
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("arst_dec_valid", dec_valid_o, 0);
    check("arst_dec_err", dec_err_o, 0);
    check("arst_dec_port", dec_port_o, 0);
    check("arst_miss_cnt", miss_cnt_o, 0);
    check("arst_locked", locked_o, 0);
    check("arst_cfg_ready", cfg_ready_o, 0);
    check("arst_req_ready", req_ready_o, 0);
    exp_q.delete();
    model_reset();
    #20;
    @(negedge clk_i) rst_ni = 1'b1;
    rdy_mode = 0; dec_ready_i = 1'b1;
    @(posedge clk_i);
    #1 mon_en = 1'b1;

    // Map cleared and unlocked after reset
    do_req('h7800_0000);
    do_cfg(5, 'h9000, 'h100, 3, 0, 1);
    do_req('h9010);
    idle(3);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
